// File: rtl/alu32.sv
// rtl/alu32.sv - 32-bit integer ALU with registered result
//
// Purpose: execute-stage arithmetic/logic unit. A, B and mode are sampled
// on a rising edge with in_valid high; the result lands in X (and
// out_valid rises) on that same edge, i.e. one cycle after issue.
// A cycle with in_valid low drops out_valid and holds X.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   A, B, mode valid this cycle
//   A, B       operands (B[4:0] is the shift amount for shift modes)
//   mode       operation select (0 NOP .. 12 PASS B, 13-15 reserved)
//   X          registered result
//   out_valid  X holds a result issued one cycle earlier
//   flag_z/n/c/v  zero, negative, carry/no-borrow, signed overflow
//                 (present only when ALU32_FLAGS_EN is defined)
//
// Optional feature macro: ALU32_FLAGS_EN
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       mode,
  output logic [WIDTH-1:0] X,
`ifdef ALU32_FLAGS_EN
  output logic             out_valid,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
`else
  output logic             out_valid
`endif
);

  localparam logic [3:0] M_NOP  = 4'd0;
  localparam logic [3:0] M_ADD  = 4'd1;
  localparam logic [3:0] M_SUB  = 4'd2;
  localparam logic [3:0] M_AND  = 4'd3;
  localparam logic [3:0] M_OR   = 4'd4;
  localparam logic [3:0] M_XOR  = 4'd5;
  localparam logic [3:0] M_SLL  = 4'd6;
  localparam logic [3:0] M_SRL  = 4'd7;
  localparam logic [3:0] M_SRA  = 4'd8;
  localparam logic [3:0] M_SLT  = 4'd9;
  localparam logic [3:0] M_SLTU = 4'd10;
  localparam logic [3:0] M_NOR  = 4'd11;
  localparam logic [3:0] M_PASS = 4'd12;

  // Only the low five bits of B steer the shifter; upper bits are ignored.
  logic [4:0]       shamt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic             slt;
  logic             sltu;

  assign shamt = B[4:0];
  assign slt   = ($signed(A) < $signed(B));
  assign sltu  = (A < B);

`ifdef ALU32_FLAGS_EN
  // 33-bit forms expose the carry; for SUB bit 32 is the borrow, so the
  // carry flag is its inverse (1 = A >= B unsigned).
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           c_next;
  logic           v_next;

  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};
  assign add_res  = sum_ext[WIDTH-1:0];
  assign sub_res  = diff_ext[WIDTH-1:0];

  always_comb begin
    c_next = 1'b0;
    v_next = 1'b0;
    case (mode)
      M_ADD: begin
        c_next = sum_ext[WIDTH];
        // Same-sign operands producing an opposite-sign sum.
        v_next = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
      end
      M_SUB: begin
        c_next = ~diff_ext[WIDTH];
        // Opposite-sign operands where the result sign differs from A.
        v_next = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
      end
      default: begin
        c_next = 1'b0;
        v_next = 1'b0;
      end
    endcase
  end
`else
  assign add_res = A + B;
  assign sub_res = A - B;
`endif

  always_comb begin
    res = '0;
    case (mode)
      M_NOP:   res = '0;
      M_ADD:   res = add_res;
      M_SUB:   res = sub_res;
      M_AND:   res = A & B;
      M_OR:    res = A | B;
      M_XOR:   res = A ^ B;
      M_SLL:   res = A << shamt;
      M_SRL:   res = A >> shamt;
      M_SRA:   res = $unsigned($signed(A) >>> shamt);
      M_SLT:   res = {{(WIDTH-1){1'b0}}, slt};
      M_SLTU:  res = {{(WIDTH-1){1'b0}}, sltu};
      M_NOR:   res = ~(A | B);
      M_PASS:  res = B;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      X         <= '0;
      out_valid <= 1'b0;
`ifdef ALU32_FLAGS_EN
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        X      <= res;
`ifdef ALU32_FLAGS_EN
        flag_z <= (res == '0);
        flag_n <= res[WIDTH-1];
        flag_c <= c_next;
        flag_v <= v_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu32.sv
// tb/tb_alu32.sv - self-checking bench for alu32
module tb_alu32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  mode;
  logic [31:0] X;
  logic        out_valid;
`ifdef ALU32_FLAGS_EN
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        flag_v;
`endif

  int checks;
  int errors;

  alu32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .mode      (mode),
    .X         (X),
`ifdef ALU32_FLAGS_EN
    .out_valid (out_valid),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
`else
    .out_valid (out_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] x;
    logic [3:0]  zncv;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic [3:0] exp);
`ifdef ALU32_FLAGS_EN
    chk({name, ".zncv"}, {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, exp});
`else
    if (exp === 4'hx) $display("unreachable %s", name);
`endif
  endtask

  // Issue one operation at the falling edge, then sample after the next rise.
  task automatic issue(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    mode     = m;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    mode     = 4'd1;
    A        = 32'hFFFF_FFFF;
    B        = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //          name          mode   A             B             X             ZNCV
    vecs[0]  = '{"add",       4'd1,  32'h00000001, 32'h00000002, 32'h00000003, 4'b0000};
    vecs[1]  = '{"sub_neg",   4'd2,  32'h0000000A, 32'h00000020, 32'hFFFFFFEA, 4'b0100};
    vecs[2]  = '{"add_ovf",   4'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101};
    vecs[3]  = '{"and",       4'd3,  32'h000000CC, 32'h000000CA, 32'h000000C8, 4'b0000};
    vecs[4]  = '{"or",        4'd4,  32'h000000CC, 32'h000000CA, 32'h000000CE, 4'b0000};
    vecs[5]  = '{"xor",       4'd5,  32'h000000CC, 32'h000000CA, 32'h00000006, 4'b0000};
    vecs[6]  = '{"nor",       4'd11, 32'h000000CC, 32'h000000CA, 32'hFFFFFF31, 4'b0100};
    vecs[7]  = '{"sll",       4'd6,  32'h000000CC, 32'h00000002, 32'h00000330, 4'b0000};
    vecs[8]  = '{"srl",       4'd7,  32'h000000CC, 32'h00000002, 32'h00000033, 4'b0000};
    vecs[9]  = '{"sra_pos",   4'd8,  32'h000000CC, 32'h00000002, 32'h00000033, 4'b0000};
    vecs[10] = '{"sra_neg",   4'd8,  32'h80000000, 32'h00000022, 32'hE0000000, 4'b0100};
    vecs[11] = '{"srl_neg",   4'd7,  32'h80000000, 32'h00000022, 32'h20000000, 4'b0000};
    vecs[12] = '{"slt",       4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000};
    vecs[13] = '{"sltu",      4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000};
    vecs[14] = '{"pass_b",    4'd12, 32'h00001234, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0100};
    vecs[15] = '{"rsvd14",    4'd14, 32'h00000005, 32'h00000006, 32'h00000000, 4'b1000};
    vecs[16] = '{"nop",       4'd0,  32'h00000005, 32'h00000006, 32'h00000000, 4'b1000};
    vecs[17] = '{"rsvd13",    4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000};
    vecs[18] = '{"rsvd15",    4'd15, 32'h12345678, 32'h87654321, 32'h00000000, 4'b1000};
    vecs[19] = '{"sub_zero",  4'd2,  32'h00000005, 32'h00000005, 32'h00000000, 4'b1010};
    vecs[20] = '{"add_wrap",  4'd1,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010};
    vecs[21] = '{"sub_ovf",   4'd2,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
    vecs[22] = '{"sll_by0",   4'd6,  32'h12345678, 32'h00000020, 32'h12345678, 4'b0000};
    vecs[23] = '{"sll_31",    4'd6,  32'h00000003, 32'hFFFFFFFF, 32'h80000000, 4'b0100};
    vecs[24] = '{"slt_false", 4'd9,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b1000};
    vecs[25] = '{"sltu_true", 4'd10, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0000};

    rst      = 1'b1;
    in_valid = 1'b0;
    mode     = 4'd0;
    A        = '0;
    B        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.x", X, 32'h0);
    chk("reset.valid", {31'd0, out_valid}, 32'h0);
    chk_flags("reset", 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Idle after release: out_valid must stay low.
    idle_cycle();
    chk("idle.valid", {31'd0, out_valid}, 32'h0);
    chk("idle.x", X, 32'h0);

    foreach (vecs[i]) begin
      issue(vecs[i].mode, vecs[i].a, vecs[i].b);
      chk({vecs[i].name, ".x"}, X, vecs[i].x);
      chk({vecs[i].name, ".valid"}, {31'd0, out_valid}, 32'h1);
      chk_flags(vecs[i].name, vecs[i].zncv);
    end

    // Gap: out_valid drops, X holds last result.
    idle_cycle();
    chk("gap.valid", {31'd0, out_valid}, 32'h0);
    chk("gap.x_hold", X, 32'h00000001);

    // Back-to-back issue, four distinct modes.
    issue(4'd1, 32'h00000010, 32'h00000020);
    chk("b2b0.x", X, 32'h00000030);
    chk("b2b0.valid", {31'd0, out_valid}, 32'h1);
    issue(4'd5, 32'hFFFF0000, 32'h0F0F0F0F);
    chk("b2b1.x", X, 32'hF0F00F0F);
    chk("b2b1.valid", {31'd0, out_valid}, 32'h1);
    issue(4'd6, 32'h00000001, 32'h0000001F);
    chk("b2b2.x", X, 32'h80000000);
    chk("b2b2.valid", {31'd0, out_valid}, 32'h1);
    issue(4'd2, 32'h00000000, 32'h00000001);
    chk("b2b3.x", X, 32'hFFFFFFFF);
    chk("b2b3.valid", {31'd0, out_valid}, 32'h1);
    idle_cycle();
    chk("b2b_gap.valid", {31'd0, out_valid}, 32'h0);
    chk("b2b_gap.x_hold", X, 32'hFFFFFFFF);
    idle_cycle();
    chk("b2b_gap2.x_hold", X, 32'hFFFFFFFF);

    // Asynchronous reset mid-run: clears immediately, discards in-flight op.
    issue(4'd12, 32'h0, 32'hCAFEF00D);
    chk("pre_rst.x", X, 32'hCAFEF00D);
    @(negedge clk);
    in_valid = 1'b1;
    mode     = 4'd12;
    B        = 32'h55555555;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst.x", X, 32'h0);
    chk("async_rst.valid", {31'd0, out_valid}, 32'h0);
    chk_flags("async_rst", 4'b0000);
    @(posedge clk);
    #1;
    chk("rst_held.x", X, 32'h0);
    chk("rst_held.valid", {31'd0, out_valid}, 32'h0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    idle_cycle();
    chk("post_rst.valid", {31'd0, out_valid}, 32'h0);
    chk("post_rst.x", X, 32'h0);
    issue(4'd1, 32'h00000002, 32'h00000003);
    chk("post_rst_op.x", X, 32'h00000005);
    chk("post_rst_op.valid", {31'd0, out_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
